uart_bus_ctrl: RTL and testbench

UART_BUS_CTRL -- requirements
Module: uart_bus_ctrl

---
 rtl/uart_bus_ctrl.sv | 141 ++++++++++++++
 tb/tb_uart_bus_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_ctrl.sv
// Bus master that sets up a memory-mapped UART, polls its control register and
// moves bytes between two TX requesters, the UART buffer and a single RX consumer.
module uart_bus_ctrl #(
  parameter logic [7:0] UART_ADDRESS = 8'h00,
  parameter logic [7:0] BAUD_DIV     = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_din,
  output logic       bus_w_en,
  output logic       bus_r_en,
  input  logic [7:0] bus_dout
);

  localparam logic [7:0] ADDR_BAUD = UART_ADDRESS;
  localparam logic [7:0] ADDR_CTRL = UART_ADDRESS + 8'd1;
  localparam logic [7:0] ADDR_BUF  = UART_ADDRESS + 8'd2;

  typedef enum logic [2:0] {
    INIT = 3'd0,
    POLL = 3'd1,
    STAT = 3'd2,
    TXW  = 3'd3,
    RXR  = 3'd4,
    RXC  = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_grant_q, last_grant_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       arb_pick;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= INIT;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      rx_valid_q   <= rx_valid_d;
      rx_data_q    <= rx_data_d;
    end
  end

  // Round robin on a tie; a lone requester always wins.
  always_comb begin
    arb_pick = req1_valid;
    if (req0_valid && req1_valid) arb_pick = ~last_grant_q;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    rx_valid_d   = rx_valid_q && !rx_ready;
    rx_data_d    = rx_data_q;
    case (state_q)
      INIT: state_d = POLL;
      POLL: state_d = STAT;
      STAT: begin
        if (bus_dout[0] && !rx_valid_q) begin
          state_d = RXR;
        end else if (bus_dout[1] && (req0_valid || req1_valid)) begin
          state_d = TXW;
          grant_d = arb_pick;
        end else begin
          state_d = POLL;
        end
      end
      TXW: begin
        last_grant_d = grant_q;
        state_d      = POLL;
      end
      RXR: state_d = RXC;
      RXC: begin
        rx_data_d  = bus_dout;
        rx_valid_d = 1'b1;
        state_d    = POLL;
      end
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    bus_addr   = ADDR_CTRL;
    bus_din    = 8'h00;
    bus_w_en   = 1'b0;
    bus_r_en   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      INIT: begin
        bus_addr = ADDR_BAUD;
        bus_din  = BAUD_DIV;
        bus_w_en = 1'b1;
      end
      POLL: bus_r_en = 1'b1;
      TXW: begin
        bus_addr   = ADDR_BUF;
        bus_din    = grant_q ? req1_data : req0_data;
        bus_w_en   = 1'b1;
        req0_ready = ~grant_q;
        req1_ready = grant_q;
      end
      RXR: begin
        bus_addr = ADDR_BUF;
        bus_r_en = 1'b1;
      end
      default: ;
    endcase
    // Reset kills any strobe in flight so an interrupted TX byte is not consumed.
    if (rst) begin
      bus_w_en   = 1'b0;
      bus_r_en   = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

  a_rw_excl: assert property (@(posedge clk) !(bus_w_en && bus_r_en));

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// Directed and randomized checks of uart_bus_ctrl against a transaction-level
// UART/requester/consumer model.
module tb_uart_bus_ctrl;
  localparam logic [7:0] BASE = 8'hFE;
  localparam logic [7:0] BAUD = 8'h1B;
  localparam logic [7:0] CTRL = 8'hFF;
  localparam logic [7:0] BUFA = 8'h00;

  logic       clk;
  logic       rst;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic       rx_valid, rx_ready;
  logic [7:0] rx_data;
  logic [7:0] bus_addr, bus_din, bus_dout;
  logic       bus_w_en, bus_r_en;

  uart_bus_ctrl #(.UART_ADDRESS(BASE), .BAUD_DIV(BAUD)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .bus_addr(bus_addr), .bus_din(bus_din), .bus_w_en(bus_w_en),
    .bus_r_en(bus_r_en), .bus_dout(bus_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] rq0[$], rq1[$], exp_rx[$], txlog[$];
  logic       rst_req, rx_ready_req, rnd;
  logic       tx_empty, rx_full, dout_v;
  logic [7:0] rx_buf, dout_n;
  int         tx_busy;
  logic       mlg, prev_v0, prev_v1, prev_rxv, rst_prev;
  logic [7:0] prev_dout;
  int         n_rdy0 = 0, n_rdy1 = 0, n_bufrd = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // All DUT inputs change here, just after the rising edge.
  task automatic drive();
    rst = rst_req;
    if (dout_v) begin
      bus_dout = dout_n;
      dout_v   = 1'b0;
    end
    if (tx_busy > 0) begin
      tx_busy--;
      if (tx_busy == 0) tx_empty = 1'b1;
    end
    if (rnd) begin
      if (rq0.size() < 4 && $urandom_range(7) == 0) rq0.push_back(8'($urandom));
      if (rq1.size() < 4 && $urandom_range(7) == 0) rq1.push_back(8'($urandom));
      if (!rx_full && $urandom_range(5) == 0) begin
        rx_full = 1'b1;
        rx_buf  = 8'($urandom);
      end
      rx_ready = 1'($urandom_range(1));
      if ($urandom_range(299) == 0) rst = 1'b1;
    end else begin
      rx_ready = rx_ready_req;
    end
    req0_valid = rq0.size() > 0;
    req0_data  = req0_valid ? rq0[0] : 8'h00;
    req1_valid = rq1.size() > 0;
    req1_data  = req1_valid ? rq1[0] : 8'h00;
  endtask

  // Observes the settled cycle and plays the UART and the reference model.
  task automatic mon();
    logic       g;
    logic [7:0] d;
    if (rst) begin
      chk("rst_strobes", 32'({bus_w_en, bus_r_en, req0_ready, req1_ready}), 32'h0);
      exp_rx.delete();
      mlg      = 1'b1;
      rst_prev = 1'b1;
    end else begin
      if (rst_prev)
        chk("init_wr", 32'({bus_w_en, bus_r_en, bus_addr, bus_din}), 32'({1'b1, 1'b0, BASE, BAUD}));
      else
        chk("init_once", 32'(bus_w_en && bus_addr == BASE), 32'h0);
      if (rst_prev) chk("rst_rx", 32'({rx_valid, rx_data}), 32'h0);
      chk("rw_excl", 32'(bus_w_en && bus_r_en), 32'h0);
      if (!bus_w_en && !bus_r_en) chk("idle_bus", 32'({bus_addr, bus_din}), 32'({CTRL, 8'h00}));
      if (bus_r_en && bus_addr == CTRL) begin
        dout_n = {6'b0, tx_empty, rx_full};
        dout_v = 1'b1;
      end else if (bus_r_en && bus_addr == BUFA) begin
        chk("rd_while_held", 32'(rx_valid), 32'h0);
        chk("rd_qual", 32'(prev_dout[0]), 32'h1);
        dout_n = rx_buf;
        dout_v = 1'b1;
        exp_rx.push_back(rx_buf);
        rx_full = 1'b0;
        n_bufrd++;
      end else if (bus_r_en) begin
        chk("rd_addr", 32'(bus_addr), 32'(CTRL));
      end
      if ((bus_w_en && bus_addr == BUFA) || req0_ready || req1_ready) begin
        g = (prev_v0 && prev_v1) ? ~mlg : prev_v1;
        chk("tx_strobes", 32'({bus_w_en, bus_addr == BUFA, req1_ready, req0_ready}),
            32'({1'b1, 1'b1, g, ~g}));
        chk("tx_prio", 32'(prev_dout[0] && !prev_rxv), 32'h0);
        chk("tx_empty", 32'(prev_dout[1]), 32'h1);
        chk("tx_q_empty", 32'(g ? rq1.size() == 0 : rq0.size() == 0), 32'h0);
        if (g ? rq1.size() > 0 : rq0.size() > 0) begin
          d = g ? rq1.pop_front() : rq0.pop_front();
          chk("tx_data", 32'(bus_din), 32'(d));
          txlog.push_back(d);
        end
        mlg = g;
        if (g) n_rdy1++; else n_rdy0++;
        tx_busy = rnd ? $urandom_range(4) : 0;
        if (tx_busy > 0) tx_empty = 1'b0;
      end
      if (rx_valid && rx_ready) begin
        chk("rx_pending", 32'(exp_rx.size() > 0), 32'h1);
        if (exp_rx.size() > 0) chk("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
      end
      rst_prev = 1'b0;
    end
    prev_v0   = req0_valid;
    prev_v1   = req1_valid;
    prev_rxv  = rx_valid;
    prev_dout = bus_dout;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    mon();
  endtask

  task automatic do_reset(input int n);
    rst_req = 1'b1;
    repeat (n) step();
    rst_req = 1'b0;
  endtask

  int n0, nb;

  initial begin
    rst = 1'b1; rst_req = 1'b1; rx_ready_req = 1'b0; rnd = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = 8'h00; req1_data = 8'h00;
    rx_ready = 1'b0; bus_dout = 8'h00;
    tx_empty = 1'b1; rx_full = 1'b0; rx_buf = 8'h00; dout_v = 1'b0; dout_n = 8'h00;
    tx_busy = 0; mlg = 1'b1; prev_v0 = 1'b0; prev_v1 = 1'b0; prev_rxv = 1'b0;
    rst_prev = 1'b1; prev_dout = 8'h00;

    // Idle: one baud write then alternating poll/status.
    do_reset(3);
    step();
    step(); chk("A_poll", 32'({bus_w_en, bus_r_en, bus_addr}), 32'({1'b0, 1'b1, CTRL}));
    step(); chk("A_stat", 32'({bus_w_en, bus_r_en, bus_addr}), 32'({1'b0, 1'b0, CTRL}));
    step(); chk("A_poll2", 32'({bus_w_en, bus_r_en, bus_addr}), 32'({1'b0, 1'b1, CTRL}));
    repeat (10) step();
    chk("A_no_tx", 32'(txlog.size()), 32'h0);

    // Single TX byte lands three cycles after the baud write.
    rq0.push_back(8'hA5);
    do_reset(2);
    n0 = n_rdy0;
    repeat (4) step();
    chk("B_txw", 32'({bus_w_en, bus_addr, bus_din, req0_ready, req1_ready}),
        32'({1'b1, BUFA, 8'hA5, 1'b1, 1'b0}));
    repeat (10) step();
    chk("B_once", 32'(n_rdy0 - n0), 32'h1);

    // Tie between requesters alternates, req0 first.
    txlog.delete();
    rq0.push_back(8'h11); rq0.push_back(8'h11);
    rq1.push_back(8'h22); rq1.push_back(8'h22);
    do_reset(2);
    repeat (20) step();
    chk("C_cnt", 32'(txlog.size()), 32'h4);
    if (txlog.size() >= 4)
      chk("C_order", {txlog[0], txlog[1], txlog[2], txlog[3]}, 32'h11221122);

    // RX beats TX; no further buffer read while the byte is held.
    rq0.push_back(8'h33);
    rx_full = 1'b1; rx_buf = 8'h5C; rx_ready_req = 1'b0;
    do_reset(2);
    repeat (4) step();
    chk("D_rxr", 32'({bus_r_en, bus_addr}), 32'({1'b1, BUFA}));
    repeat (2) step();
    chk("D_rx", 32'({rx_valid, rx_data}), 32'({1'b1, 8'h5C}));
    rx_full = 1'b1; rx_buf = 8'h66;
    nb = n_bufrd;
    repeat (12) step();
    chk("D_tx_done", 32'(rq0.size()), 32'h0);
    chk("D_no_rd", 32'(n_bufrd - nb), 32'h0);
    chk("D_hold", 32'({rx_valid, rx_data}), 32'({1'b1, 8'h5C}));
    rx_ready_req = 1'b1;
    repeat (12) step();
    chk("D_rd1", 32'(n_bufrd - nb), 32'h1);
    chk("D_drain", 32'(exp_rx.size()), 32'h0);
    rx_ready_req = 1'b0;

    // Reset during TXW aborts the write; the byte goes out once afterwards.
    rq1.push_back(8'h77);
    do_reset(2);
    repeat (3) step();
    n0 = n_rdy1;
    rst_req = 1'b1;
    step();
    chk("E_abort", 32'({req1_ready, bus_w_en}), 32'h0);
    rst_req = 1'b0;
    step();
    chk("E_init_rdy", 32'({req1_ready, bus_addr}), 32'({1'b0, BASE}));
    repeat (10) step();
    chk("E_once", 32'(n_rdy1 - n0), 32'h1);
    chk("E_q", 32'(rq1.size()), 32'h0);

    // Randomized traffic with occasional reset pulses, then drain.
    txlog.delete();
    rnd = 1'b1;
    repeat (3000) step();
    rnd = 1'b0;
    rx_ready_req = 1'b1;
    repeat (100) step();
    chk("R_tx0", 32'(rq0.size()), 32'h0);
    chk("R_tx1", 32'(rq1.size()), 32'h0);
    chk("R_rx", 32'(exp_rx.size()), 32'h0);
    chk("R_activity", 32'(txlog.size() > 20), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
